// File: rtl/register_writeback.sv
// register_writeback: write-side front end for the register file.
// Collects results from two producers (A = ALU, B = load/store) into an
// in-order DEPTH-entry FIFO and drains up to two entries per cycle onto the
// register file's two write ports. The older entry always goes to port 1.
//
// Ports:
//   iClock, iResetN        clock, synchronous active-low reset
//   iValidA/iRegA/iDataA   producer A write request, oReadyA accept
//   iValidB/iRegB/iDataB   producer B write request, oReadyB accept
//   iHold                  suppress draining this cycle
//   iFlush                 drop everything queued or on the write ports
//   oWritePort1/2          write enables toward the register file
//   oRegWrite1/2           {reg[4:0], data[15:0]} toward the register file
//   oPendingMask           one bit per register with a write still in flight
//   oIdle                  FIFO empty and both write ports idle
module register_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        iClock,
    input  logic        iResetN,
    input  logic        iValidA,
    input  logic [4:0]  iRegA,
    input  logic [15:0] iDataA,
    output logic        oReadyA,
    input  logic        iValidB,
    input  logic [4:0]  iRegB,
    input  logic [15:0] iDataB,
    output logic        oReadyB,
    input  logic        iHold,
    input  logic        iFlush,
    output logic        oWritePort1,
    output logic [20:0] oRegWrite1,
    output logic        oWritePort2,
    output logic [20:0] oRegWrite2,
    output logic [31:0] oPendingMask,
    output logic        oIdle
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [20:0]   mem_q [DEPTH];
    logic [20:0]   mem_d [DEPTH];
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          wp1_q, wp1_d, wp2_q, wp2_d;
    logic [20:0]   rw1_q, rw1_d, rw2_q, rw2_d;
    logic [31:0]   mask_q, mask_d;
    logic          idle_q, idle_d;

    logic          push_a, push_b;
    logic [1:0]    n_pop;
    logic [AW-1:0] head_p1, tail_p1, off;

    // Readiness looks only at the registered count, so a same-cycle pop
    // never lends space; this keeps push+pop from exceeding capacity.
    assign oReadyA = iResetN & (count_q <= CW'(DEPTH - 1));
    assign oReadyB = iResetN & (count_q <= CW'(DEPTH - 2));

    assign push_a  = iValidA & oReadyA;
    assign push_b  = iValidB & oReadyB;
    assign head_p1 = head_q + PTR_ONE;
    assign tail_p1 = tail_q + PTR_ONE;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wp1_d   = 1'b0;
        wp2_d   = 1'b0;
        rw1_d   = '0;
        rw2_d   = '0;
        mask_d  = '0;
        idle_d  = 1'b1;
        off     = '0;
        n_pop   = 2'd0;

        if (!iHold) begin
            if (count_q >= CW'(2))      n_pop = 2'd2;
            else if (count_q >= CW'(1)) n_pop = 2'd1;
        end

        if (iFlush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Drain: oldest entry to port 1, next-oldest to port 2.
            if (n_pop >= 2'd1) begin
                wp1_d = 1'b1;
                rw1_d = mem_q[head_q];
            end
            if (n_pop == 2'd2) begin
                wp2_d = 1'b1;
                rw2_d = mem_q[head_p1];
            end
            head_d = head_q + AW'(n_pop);

            // Enqueue: A lands first so it is the older of a same-cycle pair.
            if (push_a) mem_d[tail_q] = {iRegA, iDataA};
            if (push_b) mem_d[push_a ? tail_p1 : tail_q] = {iRegB, iDataB};
            tail_d  = tail_q + AW'(push_a) + AW'(push_b);
            count_d = count_q + CW'(push_a) + CW'(push_b) - CW'(n_pop);

            // Pending mask reflects the post-edge state: live FIFO slots
            // (offset from new head below new count) plus active ports.
            for (int i = 0; i < DEPTH; i++) begin
                off = AW'(i) - head_d;
                if (CW'(off) < count_d) mask_d[mem_d[i][20:16]] = 1'b1;
            end
            if (wp1_d) mask_d[rw1_d[20:16]] = 1'b1;
            if (wp2_d) mask_d[rw2_d[20:16]] = 1'b1;

            idle_d = (count_d == '0) & ~wp1_d & ~wp2_d;
        end
    end

    always_ff @(posedge iClock) begin
        if (!iResetN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            wp1_q   <= 1'b0;
            wp2_q   <= 1'b0;
            rw1_q   <= '0;
            rw2_q   <= '0;
            mask_q  <= '0;
            idle_q  <= 1'b1;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            wp1_q   <= wp1_d;
            wp2_q   <= wp2_d;
            rw1_q   <= rw1_d;
            rw2_q   <= rw2_d;
            mask_q  <= mask_d;
            idle_q  <= idle_d;
        end
    end

    // Storage needs no reset: only slots inside [head, head+count) are read.
    always_ff @(posedge iClock) begin
        mem_q <= mem_d;
    end

    assign oWritePort1  = wp1_q;
    assign oRegWrite1   = rw1_q;
    assign oWritePort2  = wp2_q;
    assign oRegWrite2   = rw2_q;
    assign oPendingMask = mask_q;
    assign oIdle        = idle_q;
endmodule

// File: tb/tb_register_writeback.sv
module tb_register_writeback;
    logic        iClock = 1'b0;
    logic        iResetN, iValidA, iValidB, iHold, iFlush;
    logic [4:0]  iRegA, iRegB;
    logic [15:0] iDataA, iDataB;
    logic        oReadyA, oReadyB, oWritePort1, oWritePort2, oIdle;
    logic [20:0] oRegWrite1, oRegWrite2;
    logic [31:0] oPendingMask;

    int errors = 0;
    int checks = 0;
    logic [20:0] sb[$];
    logic [15:0] rf [32];

    register_writeback #(.DEPTH(4)) dut (
        .iClock(iClock), .iResetN(iResetN),
        .iValidA(iValidA), .iRegA(iRegA), .iDataA(iDataA), .oReadyA(oReadyA),
        .iValidB(iValidB), .iRegB(iRegB), .iDataB(iDataB), .oReadyB(oReadyB),
        .iHold(iHold), .iFlush(iFlush),
        .oWritePort1(oWritePort1), .oRegWrite1(oRegWrite1),
        .oWritePort2(oWritePort2), .oRegWrite2(oRegWrite2),
        .oPendingMask(oPendingMask), .oIdle(oIdle)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic drive_a(input logic [4:0] r, input logic [15:0] d, input bit expect_accept);
        iValidA = 1'b1; iRegA = r; iDataA = d;
        if (expect_accept) sb.push_back({r, d});
    endtask

    task automatic drive_b(input logic [4:0] r, input logic [15:0] d, input bit expect_accept);
        iValidB = 1'b1; iRegB = r; iDataB = d;
        if (expect_accept) sb.push_back({r, d});
    endtask

    task automatic idle_inputs();
        iValidA = 1'b0; iValidB = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_wp1"}, 32'(oWritePort1), 32'd0);
        check({tag, "_wp2"}, 32'(oWritePort2), 32'd0);
        check({tag, "_rw1"}, 32'(oRegWrite1), 32'd0);
        check({tag, "_rw2"}, 32'(oRegWrite2), 32'd0);
        check({tag, "_mask"}, oPendingMask, 32'd0);
        check({tag, "_idle"}, 32'(oIdle), 32'd1);
    endtask

    // Monitor: every asserted write port must match the next expected entry,
    // port 1 before port 2. A small register-file model applies port 2 last.
    always @(posedge iClock) begin
        #2;
        if (oWritePort2 && !oWritePort1) check("port2_without_port1", 32'd1, 32'd0);
        if (oWritePort1) begin
            if (sb.size() == 0) check("sb_unexpected_p1", 32'(oRegWrite1), 32'h0);
            else check("sb_port1", 32'(oRegWrite1), 32'(sb.pop_front()));
            rf[oRegWrite1[20:16]] = oRegWrite1[15:0];
        end
        if (oWritePort2) begin
            if (sb.size() == 0) check("sb_unexpected_p2", 32'(oRegWrite2), 32'h0);
            else check("sb_port2", 32'(oRegWrite2), 32'(sb.pop_front()));
            rf[oRegWrite2[20:16]] = oRegWrite2[15:0];
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        iResetN = 1'b0; iHold = 1'b0; iFlush = 1'b0;
        iValidA = 1'b0; iValidB = 1'b0;
        iRegA = '0; iRegB = '0; iDataA = '0; iDataB = '0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("rst");
            check("rst_readyA", 32'(oReadyA), 32'd0);
            check("rst_readyB", 32'(oReadyB), 32'd0);
        end
        iResetN = 1'b1;
        #1;
        check("rel_readyA", 32'(oReadyA), 32'd1);
        check("rel_readyB", 32'(oReadyB), 32'd1);

        // Single write, cycle c.
        drive_a(5'd5, 16'h1234, 1);
        step(); idle_inputs();                       // c+1
        check("single_mask_c1", oPendingMask, 32'h20);
        check("single_wp1_c1", 32'(oWritePort1), 32'd0);
        step();                                      // c+2
        check("single_wp1_c2", 32'(oWritePort1), 32'd1);
        check("single_rw1_c2", 32'(oRegWrite1), 32'h051234);
        check("single_wp2_c2", 32'(oWritePort2), 32'd0);
        check("single_mask_c2", oPendingMask, 32'h20);
        step();                                      // c+3
        check("single_mask_c3", oPendingMask, 32'h0);
        check("single_idle_c3", 32'(oIdle), 32'd1);

        // Same-register pair: A older, lands on port 1; port 2 wins in the RF.
        drive_a(5'd3, 16'h0001, 1);
        drive_b(5'd3, 16'h0002, 1);
        step(); idle_inputs();
        step();
        check("pair_wp1", 32'(oWritePort1), 32'd1);
        check("pair_wp2", 32'(oWritePort2), 32'd1);
        check("pair_rw1", 32'(oRegWrite1), 32'h030001);
        check("pair_rw2", 32'(oRegWrite2), 32'h030002);
        check("pair_mask", oPendingMask, 32'h8);
        step();
        check("pair_rf_r3", 32'(rf[3]), 32'h0002);

        // Fill under hold and check backpressure.
        iHold = 1'b1;
        drive_a(5'd1, 16'h0101, 1);
        drive_b(5'd2, 16'h0202, 1);
        step(); idle_inputs();                       // count 2
        check("fill2_readyB", 32'(oReadyB), 32'd1);
        drive_a(5'd4, 16'h0404, 1);
        step(); idle_inputs();                       // count 3
        check("fill3_readyA", 32'(oReadyA), 32'd1);
        check("fill3_readyB", 32'(oReadyB), 32'd0);
        drive_a(5'd6, 16'h0606, 1);
        drive_b(5'd7, 16'h0707, 0);                  // refused, no space for B
        step(); idle_inputs();                       // count 4
        check("full_readyA", 32'(oReadyA), 32'd0);
        check("full_readyB", 32'(oReadyB), 32'd0);
        check("full_mask", oPendingMask, 32'h56);
        drive_a(5'd8, 16'h0808, 0);
        drive_b(5'd9, 16'h0909, 0);
        step(); idle_inputs();
        check("full_hold_wp1", 32'(oWritePort1), 32'd0);
        check("full_hold_mask", oPendingMask, 32'h56);
        iHold = 1'b0;
        step();
        check("drain1_wp2", 32'(oWritePort2), 32'd1);
        check("drain1_readyB", 32'(oReadyB), 32'd1);
        step();
        check("drain2_wp2", 32'(oWritePort2), 32'd1);
        check("drain2_readyA", 32'(oReadyA), 32'd1);
        step();
        check("drain_idle", 32'(oIdle), 32'd1);

        // Flush with two writes on the ports and one still queued.
        iHold = 1'b1;
        drive_a(5'd10, 16'h1010, 1);
        drive_b(5'd11, 16'h1111, 1);
        step(); idle_inputs();
        drive_a(5'd12, 16'h1212, 1);
        step(); idle_inputs();                       // count 3
        iHold = 1'b0;
        step();                                      // ports high, 1 queued
        check("preflush_wp1", 32'(oWritePort1), 32'd1);
        check("preflush_wp2", 32'(oWritePort2), 32'd1);
        check("preflush_mask", oPendingMask, 32'h1C00);
        iFlush = 1'b1;
        drive_a(5'd13, 16'h1313, 0);                 // dropped by the flush
        step(); idle_inputs();
        iFlush = 1'b0;
        sb.delete();                                 // queued entry discarded
        check_quiet("flush");
        step();
        step();
        check("postflush_idle", 32'(oIdle), 32'd1);

        // Reset mid-operation with a full FIFO.
        iHold = 1'b1;
        drive_a(5'd20, 16'h2020, 1);
        drive_b(5'd21, 16'h2121, 1);
        step();
        drive_a(5'd22, 16'h2222, 1);
        drive_b(5'd23, 16'h2323, 1);
        step(); idle_inputs();
        check("prerst_mask", oPendingMask, 32'h00F00000);
        iResetN = 1'b0;
        step();
        sb.delete();
        iResetN = 1'b1;
        iHold = 1'b0;
        check_quiet("midrst");
        #1;
        check("midrst_readyB", 32'(oReadyB), 32'd1);
        drive_a(5'd10, 16'hABCD, 1);                 // cycle c
        step(); idle_inputs();
        check("rst_lat_wp1_c1", 32'(oWritePort1), 32'd0);
        step();
        check("rst_lat_wp1_c2", 32'(oWritePort1), 32'd1);
        check("rst_lat_rw1_c2", 32'(oRegWrite1), 32'h0AABCD);
        step();
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
